// File: rtl/dma_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dma_req_arbiter
// Description : Round-robin sharing of one weight-DMA engine between N_PORT
//               layer controllers; routes engine strobes back to the granted port.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_req_arbiter #(
    parameter int N_PORT = 4,
    parameter int IDX_W  = 2,
    parameter int ADDR_W = 27,
    parameter int DW     = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_PORT-1:0]        req_vec,
    input  logic [N_PORT*ADDR_W-1:0] req_start_addr,
    input  logic [N_PORT*ADDR_W-1:0] req_length,
    output logic [N_PORT-1:0]        ack_vec,
    output logic [N_PORT-1:0]        dout_en_vec,
    output logic [N_PORT-1:0]        dout_eop_vec,
    output logic [DW-1:0]            dout,
    output logic [IDX_W-1:0]         grant_idx,
    output logic                     busy,
    output logic                     dma_req,
    input  logic                     dma_ack,
    output logic [ADDR_W-1:0]        dma_start_addr,
    output logic [ADDR_W-1:0]        dma_length,
    input  logic                     dma_dout_en,
    input  logic                     dma_dout_eop,
    input  logic [DW-1:0]            dma_dout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] c_LAST_RST = IDX_W'(N_PORT - 1);

    state_t              r_state;
    logic [IDX_W-1:0]    r_grant_idx;
    logic [IDX_W-1:0]    r_last;
    logic                r_dma_req;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_len;

    logic [ADDR_W-1:0]   w_addr_arr [N_PORT];
    logic [ADDR_W-1:0]   w_len_arr  [N_PORT];
    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_pick_any;
    int                  w_cand;
    logic [N_PORT-1:0]   w_grant_oh;
    logic                w_beat;
    logic                w_eop_beat;

    for (genvar gp = 0; gp < N_PORT; gp++) begin : g_unpack
        assign w_addr_arr[gp] = req_start_addr[gp*ADDR_W +: ADDR_W];
        assign w_len_arr[gp]  = req_length[gp*ADDR_W +: ADDR_W];
    end

    // Walk candidates from farthest to nearest so the port closest after r_last wins.
    always_comb begin
        w_pick_idx = r_last;
        w_pick_any = 1'b0;
        w_cand     = 0;
        for (int k = N_PORT; k >= 1; k--) begin
            w_cand = (int'(r_last) + k) % N_PORT;
            if (req_vec[IDX_W'(w_cand)]) begin
                w_pick_idx = IDX_W'(w_cand);
                w_pick_any = 1'b1;
            end
        end
    end

    assign w_grant_oh = N_PORT'(1) << r_grant_idx;
    assign w_beat     = (r_state == S_XFER) && dma_dout_en;
    assign w_eop_beat = w_beat && dma_dout_eop;

    assign ack_vec      = ((r_state == S_REQ) && dma_ack) ? w_grant_oh : '0;
    assign dout_en_vec  = w_beat     ? w_grant_oh : '0;
    assign dout_eop_vec = w_eop_beat ? w_grant_oh : '0;
    assign dout         = dma_dout;

    assign grant_idx      = r_grant_idx;
    assign busy           = (r_state != S_IDLE);
    assign dma_req        = r_dma_req;
    assign dma_start_addr = r_addr;
    assign dma_length     = r_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_grant_idx <= '0;
            r_last      <= c_LAST_RST;
            r_dma_req   <= 1'b0;
            r_addr      <= '0;
            r_len       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_any) begin
                        r_grant_idx <= w_pick_idx;
                        r_addr      <= w_addr_arr[w_pick_idx];
                        r_len       <= w_len_arr[w_pick_idx];
                        r_dma_req   <= 1'b1;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    // The grant holds even if the requester drops its request here.
                    if (dma_ack) begin
                        r_dma_req <= 1'b0;
                        r_state   <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (w_eop_beat) begin
                        r_last  <= r_grant_idx;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_dma_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_req_arbiter
// Description : Directed scoreboard bench for dma_req_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_req_arbiter;

    localparam int N_PORT = 4;
    localparam int IDX_W  = 2;
    localparam int ADDR_W = 27;
    localparam int DW     = 512;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N_PORT-1:0]        req_vec;
    logic [N_PORT*ADDR_W-1:0] req_start_addr;
    logic [N_PORT*ADDR_W-1:0] req_length;
    logic [N_PORT-1:0]        ack_vec;
    logic [N_PORT-1:0]        dout_en_vec;
    logic [N_PORT-1:0]        dout_eop_vec;
    logic [DW-1:0]            dout;
    logic [IDX_W-1:0]         grant_idx;
    logic                     busy;
    logic                     dma_req;
    logic                     dma_ack;
    logic [ADDR_W-1:0]        dma_start_addr;
    logic [ADDR_W-1:0]        dma_length;
    logic                     dma_dout_en;
    logic                     dma_dout_eop;
    logic [DW-1:0]            dma_dout;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    int                q_port [$];
    logic [ADDR_W-1:0] q_addr [$];
    logic [ADDR_W-1:0] q_len  [$];

    always #5 clk = ~clk;

    dma_req_arbiter #(
        .N_PORT (N_PORT),
        .IDX_W  (IDX_W),
        .ADDR_W (ADDR_W),
        .DW     (DW)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .req_vec        (req_vec),
        .req_start_addr (req_start_addr),
        .req_length     (req_length),
        .ack_vec        (ack_vec),
        .dout_en_vec    (dout_en_vec),
        .dout_eop_vec   (dout_eop_vec),
        .dout           (dout),
        .grant_idx      (grant_idx),
        .busy           (busy),
        .dma_req        (dma_req),
        .dma_ack        (dma_ack),
        .dma_start_addr (dma_start_addr),
        .dma_length     (dma_length),
        .dma_dout_en    (dma_dout_en),
        .dma_dout_eop   (dma_dout_eop),
        .dma_dout       (dma_dout)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ADDR_W-1:0] addr_of(input int p);
        return ADDR_W'(32'h1000 * (p + 1) + 32'h20);
    endfunction

    // Port 3 uses a zero length, which must be forwarded untouched.
    function automatic logic [ADDR_W-1:0] len_of(input int p);
        return (p == 3) ? '0 : ADDR_W'(2 + p);
    endfunction

    task automatic set_ports();
        for (int p = 0; p < N_PORT; p++) begin
            req_start_addr[p*ADDR_W +: ADDR_W] = addr_of(p);
            req_length[p*ADDR_W +: ADDR_W]     = len_of(p);
        end
    endtask

    task automatic expect_grant(input int p, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] l);
        q_port.push_back(p);
        q_addr.push_back(a);
        q_len.push_back(l);
    endtask

    task automatic fill_data();
        for (int i = 0; i < DW/32; i++) dma_dout[i*32 +: 32] = $urandom;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Serves the next expected grant: wait for dma_req, probe REQ, ack, stream beats.
    task automatic serve(input int beats, input int exp_wait, input bit keep_req,
                         input logic [N_PORT-1:0] eop_raise);
        int                p;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] l;
        logic [N_PORT-1:0] oh;
        int                n;
        int                pulses;
        p  = q_port.pop_front();
        a  = q_addr.pop_front();
        l  = q_len.pop_front();
        oh = N_PORT'(1) << p;
        n  = 0;
        while (dma_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (dma_req !== 1'b1) begin
            check("dma_req_timeout", DW'(dma_req), DW'(1));
            return;
        end
        if (exp_wait >= 0) check("req_latency", DW'(n), DW'(exp_wait));
        check("grant_idx", DW'(grant_idx), DW'(p));
        check("dma_start_addr", DW'(dma_start_addr), DW'(a));
        check("dma_length", DW'(dma_length), DW'(l));
        check("busy_req", DW'(busy), DW'(1));
        dma_dout_en  = 1'b1;
        dma_dout_eop = 1'b1;
        #1;
        check("en_in_req", DW'(dout_en_vec), DW'(0));
        check("eop_in_req", DW'(dout_eop_vec), DW'(0));
        check("ack_before", DW'(ack_vec), DW'(0));
        tick();
        dma_dout_en  = 1'b0;
        dma_dout_eop = 1'b0;
        check("req_held", DW'(dma_req), DW'(1));
        dma_ack = 1'b1;
        #1;
        check("ack_vec", DW'(ack_vec), DW'(oh));
        tick();
        dma_ack = 1'b0;
        if (!keep_req) req_vec[p] = 1'b0;
        #1;
        check("dma_req_clear", DW'(dma_req), DW'(0));
        check("ack_after", DW'(ack_vec), DW'(0));
        pulses = 0;
        for (int b = 0; b < beats; b++) begin
            dma_dout_en  = 1'b1;
            dma_dout_eop = (b == beats - 1);
            fill_data();
            if (b == beats - 1) req_vec = req_vec | eop_raise;
            #1;
            if (dout_en_vec[p] === 1'b1) pulses++;
            check("dout_en_vec", DW'(dout_en_vec), DW'(oh));
            check("dout_eop_vec", DW'(dout_eop_vec), (b == beats - 1) ? DW'(oh) : DW'(0));
            if (b == 0) check("dout", dout, dma_dout);
            tick();
        end
        dma_dout_en  = 1'b0;
        dma_dout_eop = 1'b0;
        #1;
        check("pulse_count", DW'(pulses), DW'(beats));
        check("busy_after_eop", DW'(busy), DW'(0));
        check("no_early_req", DW'(dma_req), DW'(0));
    endtask

    initial begin
        rst          = 1'b1;
        req_vec      = '0;
        dma_ack      = 1'b0;
        dma_dout_en  = 1'b0;
        dma_dout_eop = 1'b0;
        dma_dout     = '0;
        set_ports();
        tick();
        tick();
        check("rst_dma_req", DW'(dma_req), DW'(0));
        check("rst_grant", DW'(grant_idx), DW'(0));
        check("rst_busy", DW'(busy), DW'(0));
        check("rst_addr", DW'(dma_start_addr), DW'(0));
        check("rst_len", DW'(dma_length), DW'(0));
        check("rst_ack", DW'(ack_vec), DW'(0));
        check("rst_en", DW'(dout_en_vec), DW'(0));
        check("rst_eop", DW'(dout_eop_vec), DW'(0));
        rst = 1'b0;
        tick();

        // Single port, 100 beats; port fields change after grant and must not leak.
        req_start_addr[0 +: ADDR_W] = ADDR_W'(32'h40);
        req_length[0 +: ADDR_W]     = ADDR_W'(100);
        req_vec = 4'b0001;
        expect_grant(0, ADDR_W'(32'h40), ADDR_W'(100));
        tick();
        check("t1_latency", DW'(dma_req), DW'(1));
        req_start_addr[0 +: ADDR_W] = ADDR_W'(32'h999);
        req_length[0 +: ADDR_W]     = ADDR_W'(7);
        serve(100, 0, 1'b0, '0);

        // Simultaneous 0011 after reset, then port 2 raised on port 1's eop.
        apply_reset();
        set_ports();
        req_vec = 4'b0011;
        expect_grant(0, addr_of(0), len_of(0));
        expect_grant(1, addr_of(1), len_of(1));
        expect_grant(2, addr_of(2), len_of(2));
        serve(3, 1, 1'b0, '0);
        serve(4, 1, 1'b0, 4'b0100);
        serve(2, 1, 1'b0, '0);

        // Stray engine strobes in IDLE.
        for (int i = 0; i < 3; i++) begin
            dma_dout_en  = 1'b1;
            dma_dout_eop = 1'b1;
            dma_ack      = 1'b1;
            fill_data();
            #1;
            check("idle_en", DW'(dout_en_vec), DW'(0));
            check("idle_eop", DW'(dout_eop_vec), DW'(0));
            check("idle_ack", DW'(ack_vec), DW'(0));
            check("idle_dout", dout, dma_dout);
            tick();
            check("idle_busy", DW'(busy), DW'(0));
        end
        dma_dout_en  = 1'b0;
        dma_dout_eop = 1'b0;
        dma_ack      = 1'b0;

        // Continuous 1111 for 8 transfers.
        apply_reset();
        req_vec = 4'b1111;
        for (int i = 0; i < 8; i++) expect_grant(i % 4, addr_of(i % 4), len_of(i % 4));
        for (int i = 0; i < 8; i++) serve(2, 1, 1'b1, '0);

        // Reset on beat 50 of port 1's transfer.
        expect_grant(0, addr_of(0), len_of(0));
        serve(2, 1, 1'b1, '0);
        begin
            int n;
            n = 0;
            while (dma_req !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            check("t6_grant", DW'(grant_idx), DW'(1));
            dma_ack = 1'b1;
            tick();
            dma_ack = 1'b0;
            for (int b = 0; b < 50; b++) begin
                dma_dout_en = 1'b1;
                tick();
            end
            rst = 1'b1;
            #1;
            check("t6_beat50_en", DW'(dout_en_vec), DW'(4'b0010));
            tick();
            rst         = 1'b0;
            dma_dout_en = 1'b0;
            #1;
            check("t6_busy", DW'(busy), DW'(0));
            check("t6_dma_req", DW'(dma_req), DW'(0));
            check("t6_grant_rst", DW'(grant_idx), DW'(0));
            check("t6_en_rst", DW'(dout_en_vec), DW'(0));
        end
        expect_grant(0, addr_of(0), len_of(0));
        serve(2, 1, 1'b1, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
